// File: rtl/sram_pkg.sv
// Shared constants, state type and sense helper for the SRAM array sequencer.
package sram_pkg;

  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;

  localparam int PHASE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WL,
    SENSE,
    RESP
  } sram_state_e;

  // Returns {valid, bit}. A column is decidable only when exactly one side of
  // the pair is above threshold; undecidable columns read as 0.
  function automatic logic [1:0] sense_bit(input real bl, input real blb);
    logic bl_hi;
    logic blb_hi;
    bl_hi  = (bl >= VTH);
    blb_hi = (blb >= VTH);
    return {bl_hi ^ blb_hi, bl_hi & ~blb_hi};
  endfunction

endpackage

// File: rtl/sram_array_ctrl_if.sv
// Host-side request/response bundle of the SRAM array sequencer.
interface sram_array_ctrl_if #(
  parameter int ADDR_W = 3,
  parameter int COLS   = 8
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [COLS-1:0]   req_wdata;
  logic              rsp_valid;
  logic [COLS-1:0]   rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_row_decoder.sv
// One-hot wordline driver: the addressed row goes to VDD while enabled, all
// other rows (and every row when disabled) sit at VSS.
module sram_row_decoder
  import sram_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int ADDR_W = 3
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output real               row_v [ROWS]
);

  // Drive every wordline from the enable and the decoded address.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      row_v[r] = (en && (int'(addr) == r)) ? VDD : VSS;
    end
  end

endmodule

// File: rtl/sram_array_ctrl.sv
// Read/write sequencer for a ROWS x COLS analog-modelled 6T SRAM array.
//
// state | meaning
// IDLE  | ready for a request, bitlines precharged, wordlines off
// PRE   | precharge hold on all bitlines, T_PRE cycles
// WL    | selected wordline high, write data on bitlines, T_WL cycles
// SENSE | wordline off, read bitlines sampled into the response
// RESP  | one-cycle rsp_valid pulse
module sram_array_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int ADDR_W = 3,
  parameter int T_PRE  = 1,
  parameter int T_WL   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_array_ctrl_if.slave     bus,
  output real                  row_wr [ROWS],
  output real                  bl_wr  [COLS],
  output real                  blb_wr [COLS],
  input  real                  bl_rd  [COLS],
  input  real                  blb_rd [COLS]
);

  // Phase timers count down from (length - 1) and leave the phase at zero.
  localparam logic [PHASE_W-1:0] PRE_LOAD = PHASE_W'(T_PRE - 1);
  localparam logic [PHASE_W-1:0] WL_LOAD  = PHASE_W'(T_WL - 1);

  sram_state_e        state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLS-1:0]    wdata_q, wdata_d;
  logic [COLS-1:0]    rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [COLS-1:0]    sense_ok;
  logic [COLS-1:0]    sense_val;
  logic               addr_ok;
  logic               wl_en;

  assign addr_ok = (int'(bus.req_addr) < ROWS);
  assign wl_en   = (state_q == WL);

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  // State, phase timer, request latches and response hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Per-column sense decision on the muxed read bitlines.
  always_comb begin
    sense_ok  = '0;
    sense_val = '0;
    for (int c = 0; c < COLS; c++) begin
      {sense_ok[c], sense_val[c]} = sense_bit(bl_rd[c], blb_rd[c]);
    end
  end

  // Next-state, phase timer reloads and response capture.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (addr_ok) begin
            state_d = PRE;
            phase_d = PRE_LOAD;
          end else begin
            // Bad row: skip the array entirely and answer on the next cycle.
            state_d = RESP;
            rdata_d = '0;
            err_d   = 1'b1;
          end
        end
      end
      PRE: begin
        if (phase_q == '0) begin
          state_d = WL;
          phase_d = WL_LOAD;
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      WL: begin
        if (phase_q == '0) begin
          state_d = SENSE;
          phase_d = '0;
        end else begin
          phase_d = phase_q - PHASE_W'(1);
        end
      end
      SENSE: begin
        state_d = RESP;
        if (we_q) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end else begin
          rdata_d = sense_val;
          err_d   = ~&sense_ok;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  sram_row_decoder #(
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_row_decoder (
    .en    (wl_en),
    .addr  (addr_q),
    .row_v (row_wr)
  );

  // Bitlines stay precharged except while a write wordline is open.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      bl_wr[c]  = VDD;
      blb_wr[c] = VDD;
      if (wl_en && we_q) begin
        bl_wr[c]  = wdata_q[c] ? VDD : VSS;
        blb_wr[c] = wdata_q[c] ? VSS : VDD;
      end
    end
  end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Bench for sram_array_ctrl: behavioural cell array plus a timing-window
// reference model checked against the DUT on every falling edge.
module tb_sram_array_ctrl;

  localparam int ROWS   = 6;
  localparam int COLS   = 8;
  localparam int ADDR_W = 3;
  localparam int T_PRE  = 1;
  localparam int T_WL   = 3;
  localparam int LAT    = T_PRE + T_WL + 2;

  logic clk = 1'b0;
  logic rst_n;
  logic cmp_en = 1'b0;

  real row_wr [ROWS];
  real bl_wr  [COLS];
  real blb_wr [COLS];
  real bl_rd  [COLS];
  real blb_rd [COLS];

  sram_array_ctrl_if #(.ADDR_W(ADDR_W), .COLS(COLS)) bus ();

  sram_array_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .T_PRE(T_PRE), .T_WL(T_WL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .row_wr(row_wr), .bl_wr(bl_wr), .blb_wr(blb_wr),
    .bl_rd(bl_rd), .blb_rd(blb_rd)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // 2'b10 = drive-high level, 2'b01 = drive-low level, 2'b11 = anything else
  function automatic logic [1:0] vcode(input real v);
    if (v == 1.5) return 2'b10;
    if (v == 0.0) return 2'b01;
    return 2'b11;
  endfunction

  // ---------------- behavioural cell array ----------------
  logic [7:0] cells [8] = '{default: 8'h00};
  logic       bad_en  = 1'b0;
  int         bad_col = 0;
  logic       bad_hi  = 1'b0;

  // ---------------- reference model state ----------------
  logic       m_busy, m_we, m_oor;
  int         m_k, m_lat;
  logic [2:0] m_addr;
  logic [7:0] m_wdata, m_exp_rdata, m_held_rdata;
  logic       m_exp_err, m_held_err;
  logic [7:0] m_mem [8] = '{default: 8'h00};

  always @(negedge clk) begin
    for (int r = 0; r < ROWS; r++) begin
      if (row_wr[r] >= 0.8) begin
        for (int c = 0; c < COLS; c++) begin
          if (bl_wr[c] >= 0.8 && blb_wr[c] < 0.8) cells[r][c] <= 1'b1;
          else if (bl_wr[c] < 0.8 && blb_wr[c] >= 0.8) cells[r][c] <= 1'b0;
        end
      end
    end
  end

  // External column mux presents the row of the current operation.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      bl_rd[c]  = cells[m_addr][c] ? 1.5 : 0.0;
      blb_rd[c] = cells[m_addr][c] ? 0.0 : 1.5;
      if (bad_en && c == bad_col) begin
        bl_rd[c]  = bad_hi ? 1.5 : 0.0;
        blb_rd[c] = bad_hi ? 1.5 : 0.0;
      end
    end
  end

  function automatic logic [8:0] model_resp(input logic we, input logic [2:0] addr,
                                            input logic [7:0] stored, input logic bad_c,
                                            input int col);
    logic [7:0] d;
    if (int'(addr) >= ROWS) return {1'b1, 8'h00};
    if (we) return {1'b0, 8'h00};
    d = stored;
    if (bad_c) begin
      d[col] = 1'b0;
      return {1'b1, d};
    end
    return {1'b0, d};
  endfunction

  // Operation tracker: k counts edges since acceptance; the response is due at k == latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_k <= 0; m_lat <= 1; m_we <= 1'b0; m_oor <= 1'b0;
      m_addr <= '0; m_wdata <= '0; m_exp_rdata <= '0; m_exp_err <= 1'b0;
      m_held_rdata <= '0; m_held_err <= 1'b0;
    end else if (m_busy) begin
      if (m_k >= m_lat) begin
        m_busy <= 1'b0;
      end else begin
        m_k <= m_k + 1;
        if (m_k + 1 == m_lat) begin
          m_held_rdata <= m_exp_rdata;
          m_held_err   <= m_exp_err;
        end
      end
    end else if (bus.req_valid) begin
      m_busy  <= 1'b1;
      m_k     <= 1;
      m_we    <= bus.req_we;
      m_addr  <= bus.req_addr;
      m_wdata <= bus.req_wdata;
      m_oor   <= (int'(bus.req_addr) >= ROWS);
      m_lat   <= (int'(bus.req_addr) >= ROWS) ? 1 : LAT;
      {m_exp_err, m_exp_rdata} <= model_resp(bus.req_we, bus.req_addr, m_mem[bus.req_addr],
                                             bad_en, bad_col);
      if (int'(bus.req_addr) >= ROWS) begin
        m_held_err   <= 1'b1;
        m_held_rdata <= 8'h00;
      end else if (bus.req_we) begin
        m_mem[bus.req_addr] <= bus.req_wdata;
      end
    end
  end

  // Expected and observed analog levels, encoded for comparison.
  logic                wl_win;
  logic [2*ROWS-1:0]   act_row, exp_row;
  logic [2*COLS-1:0]   act_bl, exp_bl, act_blb, exp_blb;
  int                  nhigh;

  always_comb begin
    wl_win  = m_busy && !m_oor && (m_k >= T_PRE + 1) && (m_k <= T_PRE + T_WL);
    act_row = '0; exp_row = '0; act_bl = '0; exp_bl = '0; act_blb = '0; exp_blb = '0;
    nhigh   = 0;
    for (int r = 0; r < ROWS; r++) begin
      act_row[2*r +: 2] = vcode(row_wr[r]);
      exp_row[2*r +: 2] = (wl_win && int'(m_addr) == r) ? 2'b10 : 2'b01;
      if (row_wr[r] >= 1.5) nhigh = nhigh + 1;
    end
    for (int c = 0; c < COLS; c++) begin
      act_bl[2*c +: 2]  = vcode(bl_wr[c]);
      act_blb[2*c +: 2] = vcode(blb_wr[c]);
      exp_bl[2*c +: 2]  = (wl_win && m_we) ? (m_wdata[c] ? 2'b10 : 2'b01) : 2'b10;
      exp_blb[2*c +: 2] = (wl_win && m_we) ? (m_wdata[c] ? 2'b01 : 2'b10) : 2'b10;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", bus.req_ready, !m_busy);
      chk("rsp_valid", bus.rsp_valid, m_busy && (m_k == m_lat));
      chk("rsp_rdata", bus.rsp_rdata, m_held_rdata);
      chk("rsp_err",   bus.rsp_err,   m_held_err);
      chk("row_wr",    act_row, exp_row);
      chk("bl_wr",     act_bl,  exp_bl);
      chk("blb_wr",    act_blb, exp_blb);
      chk("one_row_high", (nhigh <= 1), 1'b1);
    end
  end

  // Issue one request from an idle falling edge; returns after the cycle following rsp_valid.
  task automatic do_op(input logic we, input logic [2:0] addr, input logic [7:0] wdata,
                       input logic rnd_hold, output logic [7:0] rdata, output logic err,
                       output int lat);
    int hold;
    hold = 0;
    if (rnd_hold && int'(addr) < ROWS) hold = $urandom_range(0, LAT - 2);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    for (int i = 0; i < hold; i++) begin
      bus.req_we    = 1'($urandom);
      bus.req_addr  = 3'($urandom);
      bus.req_wdata = 8'($urandom);
      @(negedge clk);
      lat++;
    end
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_arrived", bus.rsp_valid, 1'b1);
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lt;
    logic       op_we;
    logic [2:0] op_addr;
    logic [7:0] op_wd;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst_n = 1'b0;
    @(posedge clk);
    cmp_en = 1'b1;
    @(negedge clk);

    // reset values
    for (int r = 0; r < ROWS; r++) chk("rst_row_wr", vcode(row_wr[r]), 2'b01);
    for (int c = 0; c < COLS; c++) begin
      chk("rst_bl_wr",  vcode(bl_wr[c]),  2'b10);
      chk("rst_blb_wr", vcode(blb_wr[c]), 2'b10);
    end
    chk("rst_ready", bus.req_ready, 1'b1);
    chk("rst_valid", bus.rsp_valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // write then read row 3
    do_op(1'b1, 3'd3, 8'hA5, 1'b0, rd, er, lt);
    chk("wr3_lat", lt, LAT);
    chk("wr3_rdata", rd, 8'h00);
    do_op(1'b0, 3'd3, 8'h00, 1'b0, rd, er, lt);
    chk("rd3_lat", lt, LAT);
    chk("rd3_rdata", rd, 8'hA5);
    chk("rd3_err", er, 1'b0);

    // row isolation
    do_op(1'b1, 3'd2, 8'hFF, 1'b0, rd, er, lt);
    do_op(1'b1, 3'd5, 8'h00, 1'b0, rd, er, lt);
    do_op(1'b0, 3'd2, 8'h00, 1'b0, rd, er, lt);
    chk("rd2_rdata", rd, 8'hFF);
    do_op(1'b0, 3'd5, 8'h00, 1'b0, rd, er, lt);
    chk("rd5_rdata", rd, 8'h00);
    chk("rd5_err", er, 1'b0);

    // out-of-range row
    do_op(1'b0, 3'd7, 8'h00, 1'b0, rd, er, lt);
    chk("oor_lat", lt, 1);
    chk("oor_err", er, 1'b1);
    chk("oor_rdata", rd, 8'h00);

    // undecidable column 4 on a row of ones
    bad_en = 1'b1; bad_col = 4; bad_hi = 1'b1;
    do_op(1'b0, 3'd2, 8'h00, 1'b0, rd, er, lt);
    bad_en = 1'b0;
    chk("badsense_rdata", rd, 8'hEF);
    chk("badsense_err", er, 1'b1);

    // randomized traffic
    for (int n = 0; n < 150; n++) begin
      op_we   = 1'($urandom);
      op_addr = 3'($urandom);
      op_wd   = 8'($urandom);
      if (!op_we && $urandom_range(0, 5) == 0) begin
        bad_en  = 1'b1;
        bad_col = $urandom_range(0, COLS - 1);
        bad_hi  = 1'($urandom);
      end
      do_op(op_we, op_addr, op_wd, 1'b1, rd, er, lt);
      bad_en = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // reset in the middle of a write wordline
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 3'd1;
    bus.req_wdata = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (T_PRE) @(negedge clk);
    chk("midop_wl_high", vcode(row_wr[1]), 2'b10);
    #2 rst_n = 1'b0;
    #1;
    for (int r = 0; r < ROWS; r++) chk("midop_row_wr", vcode(row_wr[r]), 2'b01);
    for (int c = 0; c < COLS; c++) begin
      chk("midop_bl_wr",  vcode(bl_wr[c]),  2'b10);
      chk("midop_blb_wr", vcode(blb_wr[c]), 2'b10);
    end
    chk("midop_valid", bus.rsp_valid, 1'b0);
    chk("midop_ready", bus.req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b1, 3'd1, 8'h5A, 1'b0, rd, er, lt);
    chk("post_rst_wr_lat", lt, LAT);
    do_op(1'b0, 3'd1, 8'h00, 1'b0, rd, er, lt);
    chk("post_rst_rdata", rd, 8'h5A);
    chk("post_rst_err", er, 1'b0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
